load_store_unit: RTL and testbench

//  Sits between the core datapath and data_memory. It turns byte, halfword and word

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  // Access size as encoded on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  // Control states of the unit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    ERR   = 3'd4
  } state_e;

  // True when the byte offset does not match the natural alignment of the size.
  // The illegal size is reported separately by the caller.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] byte_off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = byte_off[0];
      SZ_WORD: mis = (byte_off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extraction and store merge (little-endian).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign shamt   = {byte_off, 3'b000};
  assign shifted = old_word >> shamt;

  // Pick the addressed lane(s) and sign- or zero-extend.
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    load_val = old_word;
    case (size)
      SZ_BYTE: load_val = is_unsigned ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = is_unsigned ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = old_word;
    endcase
  end

  // Replace only the addressed lane(s) of the old word with the store data.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: lane_mask = 32'h0000_00FF << shamt;
      SZ_HALF: lane_mask = 32'h0000_FFFF << shamt;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    merged = (old_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word accesses into word accesses on data_memory,
// using read-modify-write for sub-word stores. ADDR_WORD_BITS must be at most 29.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WORD_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        req_we_q, req_we_d;
  size_e       size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  byte_off_q, byte_off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  size_e       req_size_e;
  logic        req_has_err;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_size_e  = size_e'(req_size);
  assign req_has_err = (req_size_e == SZ_ILLEGAL)
                    || is_misaligned(req_size_e, req_addr[1:0])
                    || (|req_addr[31:ADDR_WORD_BITS+2]);

  lsu_lane_align u_lane_align (
    .old_word    (mem_rd),
    .wdata       (wdata_q),
    .byte_off    (byte_off_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  // Next-state, request capture and memory address/data selection.
  always_comb begin
    state_d    = state_q;
    req_we_d   = req_we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    byte_off_d = byte_off_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    mem_wd_d   = mem_wd_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_we_d   = req_we;
          size_d     = req_size_e;
          unsigned_d = req_unsigned;
          byte_off_d = req_addr[1:0];
          wdata_d    = req_wdata;
          if (req_has_err) begin
            state_d = ERR;
          end else begin
            mem_a_d = 32'(req_addr[ADDR_WORD_BITS+1:2]);
            if (req_we && (req_size_e == SZ_WORD)) begin
              mem_wd_d = req_wdata;
              state_d  = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD:    state_d = MERGE;
      MERGE: begin
        if (req_we_q) begin
          mem_wd_d = merged;
          state_d  = WR;
        end else begin
          state_d = IDLE;
        end
      end
      WR:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_we_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      byte_off_q <= 2'b00;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_we_q   <= req_we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      byte_off_q <= byte_off_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  // Outputs decoded from the state register so reset removes them at once.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign mem_we     = (state_q == WR);
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;
  assign resp_err   = (state_q == ERR);
  assign resp_valid = (state_q == ERR) || (state_q == WR) || ((state_q == MERGE) && !req_we_q);
  assign resp_rdata = ((state_q == MERGE) && !req_we_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 1-cycle-read data memory.
module tb_load_store_unit;

  typedef struct {
    logic        err;
    logic        load;
    logic [31:0] rdata;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    int          lat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [1024];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  load_store_unit #(.ADDR_WORD_BITS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_a        (mem_a),
    .mem_we       (mem_we),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // data_memory model: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:0]] <= mem_wd;
    mem_rd <= mem[mem_a[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic load, input logic [31:0] rdata,
                              input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                              input int lat);
    exp_t e;
    e.err = err; e.load = load; e.rdata = rdata;
    e.wr = wr; e.wa = wa; e.wd = wd; e.lat = lat; e.cyc = 0;
    return e;
  endfunction

  // Present a request and hold it until accepted; push the expected response.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input exp_t e_in, output int acc);
    exp_t e;
    int   n;
    e = e_in;
    n = 0;
    acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: addr 0x%08h never accepted", addr);
    end else begin
      acc   = cyc;
      e.cyc = cyc + e.lat;
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  // Drop req_valid and wait (bounded) for every expected response.
  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_we && !resp_valid) check("we_without_resp", 32'(mem_we), 32'd0);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: err=%0b rdata=0x%08h", resp_err, resp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_mem_we", 32'(mem_we), 32'(e.wr));
          if (e.load) check("resp_rdata", resp_rdata, e.rdata);
          if (e.wr) begin
            check("mem_a", mem_a, e.wa);
            check("mem_wd", mem_wd, e.wd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2, n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);

    // sw at 0x10
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, mk(0, 0, 0, 1, 32'd4, 32'hDEADBEEF, 1), acc);
    drain("drain_sw");

    // sub-word and word loads from word 4 = 0xDEADBEEF
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, mk(0, 1, 32'hFFFFFFDE, 0, 0, 0, 2), acc);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, mk(0, 1, 32'h000000DE, 0, 0, 0, 2), acc);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, mk(0, 1, 32'hFFFFDEAD, 0, 0, 0, 2), acc);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, mk(0, 1, 32'h0000BEEF, 0, 0, 0, 2), acc);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, mk(0, 1, 32'hFFFFFFEF, 0, 0, 0, 2), acc);
    drain("drain_loads");

    // sb read-modify-write then read back
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, mk(0, 0, 0, 1, 32'd4, 32'hDEAD55EF, 3), acc);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(0, 1, 32'hDEAD55EF, 0, 0, 0, 2), acc);
    drain("drain_sb");

    // error cases
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, mk(1, 0, 0, 0, 0, 0, 1), acc);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, mk(1, 0, 0, 0, 0, 0, 1), acc);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, mk(1, 0, 0, 0, 0, 0, 1), acc);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, mk(1, 0, 0, 0, 0, 0, 1), acc);
    issue(1'b1, 2'b10, 1'b0, 32'h1010, 32'h12345678, mk(1, 0, 0, 0, 0, 0, 1), acc);
    drain("drain_err");

    // back-to-back with req_valid held high
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, mk(0, 0, 0, 1, 32'd8, 32'h11223344, 1), acc);
    drain("drain_sw20");
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000A5, mk(0, 0, 0, 1, 32'd8, 32'h11A53344, 3), acc1);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, mk(0, 1, 32'h11A53344, 0, 0, 0, 2), acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'd4);
    drain("drain_b2b");

    // reset during the WR state of an sh
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, mk(0, 0, 0, 1, 32'd4, 32'h123455EF, 3), acc);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (cyc != acc + 3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("wr_before_reset", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("we_drop_on_reset", 32'(mem_we), 32'd0);
    check("ready_during_reset", 32'(req_ready), 32'd0);
    check("resp_during_reset", 32'(resp_valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mk(0, 1, 32'hDEAD55EF, 0, 0, 0, 2), acc);
    drain("drain_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
